// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: PC / IF/ID / ID/EX hold and flush arbitration.
// Optional saturating perf counters are built when HAZ_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             idex_memread,
   input  logic [4:0]       idex_rt,
   input  logic [4:0]       ifid_rs,
   input  logic [4:0]       ifid_rt,
   input  logic             ifid_uses_rt,
   input  logic             branch_taken,
   input  logic             jump,
   input  logic             dmem_req,
   input  logic             dmem_ready,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             idex_write,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             stall,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_count
);

   typedef enum logic [1:0] {
      ST_RUN        = 2'd0,
      ST_LOAD_STALL = 2'd1,
      ST_MEM_WAIT   = 2'd2
   } state_t;

   localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

   state_t     state_q, state_d;
   logic [7:0] wait_cnt_q, wait_cnt_d;
   logic       mem_timeout_q, mem_timeout_d;

   logic       mem_busy;
   logic       rs_match;
   logic       rt_match;
   logic       load_use;
   logic       wait_expired;

   // Hazard detection terms; $zero as load target never forwards a value.
   always_comb begin
      mem_busy     = dmem_req & ~dmem_ready;
      rs_match     = (idex_rt == ifid_rs);
      rt_match     = ifid_uses_rt & (idex_rt == ifid_rt);
      load_use     = idex_memread & (idex_rt != 5'd0)
                   & (rs_match | rt_match);
      wait_expired = (wait_cnt_q == TIMEOUT_CNT);
   end

   // State, wait counter and sticky timeout flag.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= ST_RUN;
         wait_cnt_q    <= 8'd0;
         mem_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         wait_cnt_q    <= wait_cnt_d;
         mem_timeout_q <= mem_timeout_d;
      end
   end

   // Next-state selection; RUN resolves memory stall, branch, load-use in order.
   always_comb begin
      state_d       = state_q;
      wait_cnt_d    = wait_cnt_q;
      mem_timeout_d = mem_timeout_q;
      unique case (state_q)
         ST_RUN: begin
            if (mem_busy) begin
               state_d    = ST_MEM_WAIT;
               wait_cnt_d = 8'd1;
            end else if (branch_taken) begin
               state_d = ST_RUN;
            end else if (load_use) begin
               state_d = ST_LOAD_STALL;
            end
         end
         ST_LOAD_STALL: begin
            state_d = ST_RUN;
         end
         ST_MEM_WAIT: begin
            if (dmem_ready) begin
               state_d    = ST_RUN;
               wait_cnt_d = 8'd0;
            end else if (wait_expired) begin
               state_d       = ST_RUN;
               wait_cnt_d    = 8'd0;
               mem_timeout_d = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end
         end
         default: begin
            state_d    = ST_RUN;
            wait_cnt_d = 8'd0;
         end
      endcase
   end

   // Latch enables and flushes; reset holds every latch and bubbles both.
   always_comb begin
      pc_write   = 1'b1;
      ifid_write = 1'b1;
      idex_write = 1'b1;
      ifid_flush = 1'b0;
      idex_flush = 1'b0;
      if (!rst_n) begin
         pc_write   = 1'b0;
         ifid_write = 1'b0;
         idex_write = 1'b0;
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
      end else begin
         unique case (state_q)
            ST_RUN: begin
               if (mem_busy) begin
                  pc_write   = 1'b0;
                  ifid_write = 1'b0;
                  idex_write = 1'b0;
               end else if (branch_taken) begin
                  ifid_flush = 1'b1;
                  idex_flush = 1'b1;
               end else if (load_use) begin
                  pc_write   = 1'b0;
                  ifid_write = 1'b0;
                  idex_flush = 1'b1;
               end else if (jump) begin
                  ifid_flush = 1'b1;
               end
            end
            ST_LOAD_STALL: begin
               if (branch_taken) begin
                  ifid_flush = 1'b1;
                  idex_flush = 1'b1;
               end
            end
            ST_MEM_WAIT: begin
               if (!dmem_ready) begin
                  if (wait_expired) begin
                     pc_write   = 1'b0;
                     ifid_flush = 1'b1;
                     idex_flush = 1'b1;
                  end else begin
                     pc_write   = 1'b0;
                     ifid_write = 1'b0;
                     idex_write = 1'b0;
                  end
               end
            end
            default: begin
               pc_write = 1'b1;
            end
         endcase
      end
   end

   assign stall       = ~(pc_write & ifid_write & idex_write);
   assign mem_timeout = mem_timeout_q;

`ifdef HAZ_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
   logic [CNT_W-1:0] flush_count_q, flush_count_d;

   // Saturating increments for stall cycles and flush events.
   always_comb begin
      stall_cycles_d = stall_cycles_q;
      flush_count_d  = flush_count_q;
      if (stall && (stall_cycles_q != '1)) begin
         stall_cycles_d = stall_cycles_q + CNT_W'(1);
      end
      if ((ifid_flush | idex_flush) && (flush_count_q != '1)) begin
         flush_count_d = flush_count_q + CNT_W'(1);
      end
   end

   // Counter registers; reset cycles are never counted.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_cycles_q <= '0;
         flush_count_q  <= '0;
      end else begin
         stall_cycles_q <= stall_cycles_d;
         flush_count_q  <= flush_count_d;
      end
   end

   assign stall_cycles = stall_cycles_q;
   assign flush_count  = flush_count_q;
`else
   assign stall_cycles = '0;
   assign flush_count  = '0;
`endif

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Sequences the IF/ID and ID/EX pipeline latches and the PC of the 5-stage MIPS core.
- Detects load-use hazards, taken-branch and jump redirects, and data-memory wait states.
- Drives write-enable (hold) and flush (bubble) controls for PC, IF/ID and ID/EX.
- Single arbitration point for all pipeline stall and flush decisions.

Parameters:
MEM_TIMEOUT, 16, max cycles in MEM_WAIT before abort (range 2..255)
CNT_W, 32, width of performance counters (used only with the optional feature)

Ports:
clk  input  1  core clock; all state updates on rising edge
rst_n  input  1  synchronous reset, active low
idex_memread  input  1  MemRead held in the ID/EX latch
idex_rt  input  5  load destination register in ID/EX (instr[20:16])
ifid_rs  input  5  rs of instruction in IF/ID
ifid_rt  input  5  rt of instruction in IF/ID
ifid_uses_rt  input  1  IF/ID instruction reads rt as a source
branch_taken  input  1  branch resolved taken in EX
jump  input  1  jump decoded in ID
dmem_req  input  1  MEM stage accessing data memory this cycle
dmem_ready  input  1  data memory completes access this cycle
pc_write  output  1  PC load enable
ifid_write  output  1  IF/ID load enable
idex_write  output  1  ID/EX load enable
ifid_flush  output  1  zero IF/ID on next edge
idex_flush  output  1  load zero-control bubble into ID/EX on next edge
stall  output  1  any of pc_write, ifid_write, idex_write is 0
mem_timeout  output  1  sticky error flag; cleared only by reset
stall_cycles  output  CNT_W  stall cycle counter (optional)
flush_count  output  CNT_W  flush event counter (optional)

Behaviour:
- States: RUN, LOAD_STALL, MEM_WAIT. State register, wait_cnt (8 bits) and mem_timeout are synchronous.
- Outputs are combinational from state and inputs. Defaults: pc_write = ifid_write = idex_write = 1; flushes = 0.
- Reset (rst_n=0 sampled at an edge): next state RUN, wait_cnt=0, mem_timeout=0, counters=0.
- While rst_n=0: all write enables = 0, ifid_flush = idex_flush = 1, stall = 1.
- Reset mid-MEM_WAIT or mid-LOAD_STALL aborts immediately to RUN.
- RUN priority, highest first:
  1. dmem_req && !dmem_ready: all writes = 0, no flush; next state MEM_WAIT, wait_cnt = 1.
  2. branch_taken: ifid_flush = 1, idex_flush = 1, pc_write = 1; stay RUN. Jump is ignored this cycle.
  3. Load-use hazard, defined as idex_memread && idex_rt != 0 && (idex_rt == ifid_rs || (ifid_uses_rt && idex_rt == ifid_rt)): pc_write = 0, ifid_write = 0, idex_flush = 1; next state LOAD_STALL.
  4. jump: ifid_flush = 1; stay RUN.
- LOAD_STALL: exactly one cycle. Default outputs, except branch_taken flushes as in RUN. Load-use is not re-evaluated. Next state RUN.
- Load-use latency: exactly one bubble per hazard.
- MEM_WAIT:
  - dmem_ready=1: default outputs; next state RUN, wait_cnt = 0.
  - Else if wait_cnt == MEM_TIMEOUT: mem_timeout <= 1, ifid_flush = idex_flush = 1, pc_write = 0; next state RUN.
  - Else: all writes = 0; wait_cnt increments.
  - branch_taken and jump are ignored; they are re-presented because EX/ID are frozen.
- dmem_ready in RUN with no dmem_req: ignored.
- Register 0 never causes a load-use stall.

Optional Feature:
HAZ_PERF_CNT_EN
- Defined: stall_cycles increments every cycle stall=1 and rst_n=1. flush_count increments on each cycle where ifid_flush or idex_flush =1 and rst_n=1. Both saturate at all-ones.
- Undefined: both ports are tied to 0 and no counter flops are built.

Test Plan:
- lw $5 in ID/EX (idex_memread=1, idex_rt=5), add with ifid_rs=5 -> cycle0: pc_write=0, ifid_write=0, idex_flush=1; cycle1: LOAD_STALL with defaults; cycle2: RUN.
- idex_rt=0, ifid_rs=0, idex_memread=1 -> no stall, all writes = 1.
- branch_taken=1 and load-use hazard in the same cycle -> ifid_flush=idex_flush=1, pc_write=1, state stays RUN.
- dmem_req=1, dmem_ready=0 for 3 cycles, then 1 -> writes = 0 for 3 cycles; 4th cycle defaults; RUN; with HAZ_PERF_CNT_EN, stall_cycles=3.
- MEM_TIMEOUT=4, dmem_ready held 0 -> after 4 frozen cycles: mem_timeout=1 (sticky), both flushes for one cycle, RUN.
- rst_n=0 for one edge during MEM_WAIT -> state RUN, wait_cnt=0, mem_timeout=0; while rst_n=0, writes = 0 and flushes = 1.
